// File: rtl/l1_cache_wb_if.sv
// l1_cache_wb_if: requester-side (fe_*) and backing-memory-side (be_*) word handshakes of the L1 cache.
// Latency: none, wires only.
// Backpressure: fe_port_ready_o throttles the requester; be_port_ready_i throttles the cache.
interface l1_cache_wb_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 8
);
    logic [ADDRESS_WIDTH-1:0] fe_address_i;
    logic                     fe_address_valid_i;
    logic [DATA_WIDTH-1:0]    fe_write_data_i;
    logic                     fe_write_data_valid_i;
    logic                     fe_read_write_select_i;
    logic [DATA_WIDTH-1:0]    fe_read_data_o;
    logic                     fe_read_data_valid_o;
    logic                     fe_write_done_o;
    logic                     fe_port_ready_o;
    logic                     fe_hit_o;

    logic [DATA_WIDTH-1:0]    be_read_data_i;
    logic                     be_read_data_valid_i;
    logic                     be_write_done_i;
    logic                     be_port_ready_i;
    logic [ADDRESS_WIDTH-1:0] be_address_o;
    logic                     be_address_valid_o;
    logic [DATA_WIDTH-1:0]    be_write_data_o;
    logic                     be_write_data_valid_o;
    logic                     be_read_write_select_o;

    // Cache side: serves the requester, masters the backing memory.
    modport slave (
        input  fe_address_i, fe_address_valid_i, fe_write_data_i, fe_write_data_valid_i,
               fe_read_write_select_i,
        output fe_read_data_o, fe_read_data_valid_o, fe_write_done_o, fe_port_ready_o, fe_hit_o,
        input  be_read_data_i, be_read_data_valid_i, be_write_done_i, be_port_ready_i,
        output be_address_o, be_address_valid_o, be_write_data_o, be_write_data_valid_o,
               be_read_write_select_o
    );

    // Environment side: requester plus backing memory.
    modport master (
        output fe_address_i, fe_address_valid_i, fe_write_data_i, fe_write_data_valid_i,
               fe_read_write_select_i,
        input  fe_read_data_o, fe_read_data_valid_o, fe_write_done_o, fe_port_ready_o, fe_hit_o,
        output be_read_data_i, be_read_data_valid_i, be_write_done_i, be_port_ready_i,
        input  be_address_o, be_address_valid_o, be_write_data_o, be_write_data_valid_o,
               be_read_write_select_o
    );
endinterface

// File: rtl/l1_cache_wb.sv
// l1_cache_wb: direct-mapped write-back / write-allocate L1 with multi-word lines and a full flush.
// Latency: hit response visible 2 edges after acceptance; misses add victim write-back and refill.
// Backpressure: fe_port_ready_o low while busy or flush pending; backend words wait on be_port_ready_i.
module l1_cache_wb #(
    parameter int DATA_WIDTH      = 16,
    parameter int ADDRESS_WIDTH   = 8,
    parameter int NUM_SETS        = 4,
    parameter int WORDS_PER_BLOCK = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic flush_i,
    output logic flush_done_o,
    l1_cache_wb_if.slave bus
);
    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int WW    = (OFF_W > 0) ? OFF_W : 1;
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDRESS_WIDTH - IDX_W - OFF_W;

    typedef logic [DATA_WIDTH-1:0]    word_t;
    typedef logic [ADDRESS_WIDTH-1:0] addr_t;
    typedef logic [TAG_W-1:0]         tag_t;
    typedef logic [IDX_W-1:0]         idx_t;
    typedef logic [WW-1:0]            woff_t;

    typedef enum logic [3:0] {
        IDLE, LOOKUP, RESPOND, EVICT_REQ, EVICT_WAIT,
        REFILL_REQ, REFILL_WAIT, FLUSH_SCAN, FLUSH_REQ, FLUSH_WAIT
    } state_t;

    localparam woff_t W0     = '0;
    localparam woff_t W_LAST = woff_t'(WORDS_PER_BLOCK - 1);
    localparam idx_t  S_LAST = idx_t'(NUM_SETS - 1);

    state_t              state_q, state_d;
    addr_t               addr_q, addr_d;
    word_t               wdata_q, wdata_d;
    logic                rw_q, rw_d;
    woff_t               w_q, w_d;
    idx_t                s_q, s_d;
    logic                pending_q, pending_d;
    logic [NUM_SETS-1:0] valid_q, valid_d, dirty_q, dirty_d;
    tag_t                tag_q [NUM_SETS];
    tag_t                tag_d [NUM_SETS];
    word_t               data_q [NUM_SETS][WORDS_PER_BLOCK];
    word_t               data_d [NUM_SETS][WORDS_PER_BLOCK];

    word_t fe_rdata_q, fe_rdata_d;
    logic  fe_rvld_q, fe_rvld_d, fe_wdone_q, fe_wdone_d, fe_hit_q, fe_hit_d;
    addr_t be_addr_q, be_addr_d;
    word_t be_wdata_q, be_wdata_d;
    logic  be_avld_q, be_avld_d, be_wvld_q, be_wvld_d, be_rw_q, be_rw_d;
    logic  flush_done_q, flush_done_d;

    // Fields of the latched request address.
    woff_t req_off;
    idx_t  req_idx;
    tag_t  req_tag;
    assign req_off = woff_t'(addr_q & addr_t'(WORDS_PER_BLOCK - 1));
    assign req_idx = idx_t'(addr_q >> OFF_W);
    assign req_tag = tag_t'(addr_q >> (OFF_W + IDX_W));

    logic  ready, accept, hit, in_flush, w_last, s_last;
    woff_t w_next;
    assign ready    = (state_q == IDLE) && !pending_q;
    assign accept   = ready && bus.fe_address_valid_i &&
                      (!bus.fe_read_write_select_i || bus.fe_write_data_valid_i);
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign in_flush = (state_q == FLUSH_SCAN) || (state_q == FLUSH_REQ) || (state_q == FLUSH_WAIT);
    assign w_last   = (w_q == W_LAST);
    assign s_last   = (s_q == S_LAST);
    assign w_next   = w_q + woff_t'(1);

    function automatic addr_t mk_addr(input tag_t t, input idx_t i, input woff_t o);
        logic [31:0] a;
        a = (32'(t) << (OFF_W + IDX_W)) | (32'(i) << OFF_W);
        if (OFF_W > 0) a = a | 32'(o);
        return addr_t'(a);
    endfunction

    // Next-state, array updates and registered outputs for the whole controller.
    always_comb begin
        logic  start_req, req_rw, set_done;
        addr_t req_addr;
        word_t req_wdata;
        state_d = state_q;     addr_d = addr_q;     wdata_d = wdata_q;   rw_d = rw_q;
        w_d = w_q;             s_d = s_q;           pending_d = pending_q;
        valid_d = valid_q;     dirty_d = dirty_q;   tag_d = tag_q;       data_d = data_q;
        fe_rdata_d = fe_rdata_q; fe_rvld_d = fe_rvld_q; fe_wdone_d = fe_wdone_q; fe_hit_d = fe_hit_q;
        be_addr_d = be_addr_q; be_avld_d = be_avld_q; be_wdata_d = be_wdata_q;
        be_wvld_d = be_wvld_q; be_rw_d = be_rw_q;   flush_done_d = 1'b0;
        start_req = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0; set_done = 1'b0;

        // A flush request arriving mid-flush is absorbed by the running flush.
        if (!in_flush) pending_d = pending_q | flush_i;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d     = bus.fe_address_i;
                    wdata_d    = bus.fe_write_data_i;
                    rw_d       = bus.fe_read_write_select_i;
                    fe_rvld_d  = 1'b0;
                    fe_wdone_d = 1'b0;
                    fe_hit_d   = 1'b0;
                    state_d    = LOOKUP;
                end else if (pending_q || flush_i) begin
                    s_d     = '0;
                    state_d = FLUSH_SCAN;
                end
            end
            LOOKUP: begin
                fe_hit_d = hit;
                w_d      = '0;
                if (hit) begin
                    state_d = RESPOND;
                end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                    start_req = 1'b1; req_rw = 1'b1;
                    req_addr  = mk_addr(tag_q[req_idx], req_idx, W0);
                    req_wdata = data_q[req_idx][W0];
                    state_d   = EVICT_REQ;
                end else begin
                    start_req = 1'b1;
                    req_addr  = mk_addr(req_tag, req_idx, W0);
                    state_d   = REFILL_REQ;
                end
            end
            RESPOND: begin
                if (rw_q) begin
                    data_d[req_idx][req_off] = wdata_q;
                    dirty_d[req_idx]         = 1'b1;
                    fe_wdone_d               = 1'b1;
                end else begin
                    fe_rdata_d = data_q[req_idx][req_off];
                    fe_rvld_d  = 1'b1;
                end
                state_d = IDLE;
            end
            EVICT_REQ, REFILL_REQ, FLUSH_REQ: begin
                if (bus.be_port_ready_i) begin
                    be_avld_d = 1'b0;
                    be_wvld_d = 1'b0;
                    state_d   = (state_q == EVICT_REQ)  ? EVICT_WAIT :
                                (state_q == REFILL_REQ) ? REFILL_WAIT : FLUSH_WAIT;
                end
            end
            EVICT_WAIT: begin
                if (bus.be_write_done_i) begin
                    start_req = 1'b1;
                    if (w_last) begin
                        dirty_d[req_idx] = 1'b0;
                        w_d      = '0;
                        req_addr = mk_addr(req_tag, req_idx, W0);
                        state_d  = REFILL_REQ;
                    end else begin
                        w_d       = w_next;
                        req_rw    = 1'b1;
                        req_addr  = mk_addr(tag_q[req_idx], req_idx, w_next);
                        req_wdata = data_q[req_idx][w_next];
                        state_d   = EVICT_REQ;
                    end
                end
            end
            REFILL_WAIT: begin
                if (bus.be_read_data_valid_i) begin
                    data_d[req_idx][w_q] = bus.be_read_data_i;
                    if (w_last) begin
                        valid_d[req_idx] = 1'b1;
                        tag_d[req_idx]   = req_tag;
                        dirty_d[req_idx] = 1'b0;
                        state_d          = RESPOND;
                    end else begin
                        w_d       = w_next;
                        start_req = 1'b1;
                        req_addr  = mk_addr(req_tag, req_idx, w_next);
                        state_d   = REFILL_REQ;
                    end
                end
            end
            FLUSH_SCAN: begin
                if (valid_q[s_q] && dirty_q[s_q]) begin
                    w_d       = '0;
                    start_req = 1'b1; req_rw = 1'b1;
                    req_addr  = mk_addr(tag_q[s_q], s_q, W0);
                    req_wdata = data_q[s_q][W0];
                    state_d   = FLUSH_REQ;
                end else begin
                    set_done = 1'b1;
                end
            end
            FLUSH_WAIT: begin
                if (bus.be_write_done_i) begin
                    if (w_last) begin
                        set_done = 1'b1;
                    end else begin
                        w_d       = w_next;
                        start_req = 1'b1; req_rw = 1'b1;
                        req_addr  = mk_addr(tag_q[s_q], s_q, w_next);
                        req_wdata = data_q[s_q][w_next];
                        state_d   = FLUSH_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Current flush set is clean now: invalidate it and move on or finish.
        if (set_done) begin
            valid_d[s_q] = 1'b0;
            dirty_d[s_q] = 1'b0;
            if (s_last) begin
                flush_done_d = 1'b1;
                pending_d    = 1'b0;
                state_d      = IDLE;
            end else begin
                s_d     = s_q + idx_t'(1);
                state_d = FLUSH_SCAN;
            end
        end

        // Backend outputs are loaded on entry to a *_REQ state so valid is up in its first cycle.
        if (start_req) begin
            be_addr_d  = req_addr;
            be_avld_d  = 1'b1;
            be_rw_d    = req_rw;
            be_wdata_d = req_wdata;
            be_wvld_d  = req_rw;
        end
    end

    // State register; reset abandons any backend transaction and clears all line state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;   addr_q <= '0;   wdata_q <= '0;  rw_q <= 1'b0;
            w_q <= '0;         s_q <= '0;      pending_q <= 1'b0;
            valid_q <= '0;     dirty_q <= '0;
            fe_rdata_q <= '0;  fe_rvld_q <= 1'b0; fe_wdone_q <= 1'b0; fe_hit_q <= 1'b0;
            be_addr_q <= '0;   be_avld_q <= 1'b0; be_wdata_q <= '0;
            be_wvld_q <= 1'b0; be_rw_q <= 1'b0;   flush_done_q <= 1'b0;
        end else begin
            state_q <= state_d;   addr_q <= addr_d;   wdata_q <= wdata_d;  rw_q <= rw_d;
            w_q <= w_d;           s_q <= s_d;         pending_q <= pending_d;
            valid_q <= valid_d;   dirty_q <= dirty_d;
            fe_rdata_q <= fe_rdata_d; fe_rvld_q <= fe_rvld_d; fe_wdone_q <= fe_wdone_d;
            fe_hit_q <= fe_hit_d;
            be_addr_q <= be_addr_d;   be_avld_q <= be_avld_d; be_wdata_q <= be_wdata_d;
            be_wvld_q <= be_wvld_d;   be_rw_q <= be_rw_d;     flush_done_q <= flush_done_d;
        end
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign bus.fe_read_data_o         = fe_rdata_q;
    assign bus.fe_read_data_valid_o   = fe_rvld_q;
    assign bus.fe_write_done_o        = fe_wdone_q;
    assign bus.fe_hit_o               = fe_hit_q;
    assign bus.fe_port_ready_o        = ready;
    assign bus.be_address_o           = be_addr_q;
    assign bus.be_address_valid_o     = be_avld_q;
    assign bus.be_write_data_o        = be_wdata_q;
    assign bus.be_write_data_valid_o  = be_wvld_q;
    assign bus.be_read_write_select_o = be_rw_q;
    assign flush_done_o               = flush_done_q;
endmodule

// File: tb/tb_l1_cache_wb.sv
// tb_l1_cache_wb: directed plus randomized checks of l1_cache_wb against a behavioural cache model.
// Latency: backing memory answers 1-3 cycles after accepting a word.
// Backpressure: memory holds be_port_ready_i low while busy.
`timescale 1ns/1ps
module tb_l1_cache_wb;
    logic clk = 1'b0;
    logic reset, flush;
    logic flush_done;
    always #5 clk = ~clk;

    l1_cache_wb_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(8)) bus ();

    l1_cache_wb #(.DATA_WIDTH(16), .ADDRESS_WIDTH(8), .NUM_SETS(4), .WORDS_PER_BLOCK(2)) dut (
        .clk_i(clk), .reset_i(reset), .flush_i(flush), .flush_done_o(flush_done), .bus(bus)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Backing memory: accepts a word when ready and valid meet at an edge.
    logic [15:0] mem [256];
    int be_wr_cnt = 0;
    int be_rd_cnt = 0;
    initial begin
        logic [7:0]  a;
        logic [15:0] d;
        logic        rw;
        for (int k = 0; k < 256; k++) mem[k] = 16'(k + 16'h100);
        bus.be_port_ready_i = 1'b1;
        bus.be_read_data_valid_i = 1'b0;
        bus.be_write_done_i = 1'b0;
        bus.be_read_data_i = '0;
        forever begin
            @(negedge clk);
            bus.be_port_ready_i = 1'b1;
            if (bus.be_address_valid_o) begin
                a = bus.be_address_o; rw = bus.be_read_write_select_o; d = bus.be_write_data_o;
                @(negedge clk);
                bus.be_port_ready_i = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                if (rw) begin
                    mem[a] = d; be_wr_cnt++; bus.be_write_done_i = 1'b1;
                end else begin
                    bus.be_read_data_i = mem[a]; be_rd_cnt++; bus.be_read_data_valid_i = 1'b1;
                end
                @(negedge clk);
                bus.be_write_done_i = 1'b0;
                bus.be_read_data_valid_i = 1'b0;
            end
        end
    end

    // Reference: coherent memory image plus per-set line state (valid, tag, dirty).
    logic [15:0] ref_mem [256];
    bit rv [4];
    int rt [4];
    bit rdt [4];

    task automatic wait_rdy();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.fe_port_ready_o && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) chk("rdy_timeout", bus.fe_port_ready_o, 1);
    endtask

    task automatic do_req(input bit rw, input logic [7:0] a, input logic [15:0] d, input bit wf);
        int set_i, tg, n, wr0, rd0, exp_wr, exp_rd;
        bit hit, done;
        logic [15:0] exp_d;
        wait_rdy();
        bus.fe_address_i = a; bus.fe_read_write_select_i = rw; bus.fe_write_data_i = d;
        bus.fe_address_valid_i = 1'b1; bus.fe_write_data_valid_i = rw; flush = wf;
        set_i = (int'(a) >> 1) & 3;
        tg = int'(a) >> 3;
        hit = rv[set_i] && (rt[set_i] == tg);
        exp_wr = (!hit && rv[set_i] && rdt[set_i]) ? 2 : 0;
        exp_rd = hit ? 0 : 2;
        if (!hit) begin rv[set_i] = 1; rt[set_i] = tg; rdt[set_i] = 0; end
        if (rw) begin rdt[set_i] = 1; ref_mem[a] = d; end
        exp_d = ref_mem[a];
        wr0 = be_wr_cnt; rd0 = be_rd_cnt;
        @(posedge clk); #1;
        bus.fe_address_valid_i = 1'b0; bus.fe_write_data_valid_i = 1'b0; flush = 1'b0;
        n = 0; done = 0;
        while (!done && n < 500) begin
            @(posedge clk); #1; n++;
            done = rw ? bus.fe_write_done_o : bus.fe_read_data_valid_o;
        end
        chk(rw ? "wr_done" : "rd_valid", done, 1);
        chk("hit", bus.fe_hit_o, hit);
        if (hit) chk("hit_latency", n, 2);
        if (!rw) chk("rd_data", bus.fe_read_data_o, exp_d);
        chk("be_writes", be_wr_cnt - wr0, exp_wr);
        chk("be_reads", be_rd_cnt - rd0, exp_rd);
        chk("ready_after", bus.fe_port_ready_o, !wf);
    endtask

    task automatic do_flush(input bit extra, input bit started);
        int n, wr0, exp_wr, pulses, bad;
        bit fd, rdy_seen;
        exp_wr = 0;
        for (int s = 0; s < 4; s++) begin
            if (rv[s] && rdt[s]) exp_wr += 2;
            rv[s] = 0; rdt[s] = 0;
        end
        if (!started) begin
            wait_rdy();
            flush = 1'b1;
            wr0 = be_wr_cnt;
            @(posedge clk); #1;
            flush = 1'b0;
        end else begin
            wr0 = be_wr_cnt;
        end
        n = 0; fd = 0; rdy_seen = 0;
        while (!fd && n < 2000) begin
            @(posedge clk); #1; n++;
            flush = extra && (n == 1);
            fd = flush_done;
            if (!fd && bus.fe_port_ready_o) rdy_seen = 1;
        end
        flush = 1'b0;
        chk("flush_done", fd, 1);
        chk("flush_ready_low", rdy_seen, 0);
        chk("flush_writes", be_wr_cnt - wr0, exp_wr);
        pulses = 0;
        repeat (8) begin @(posedge clk); #1; if (flush_done) pulses++; end
        chk("flush_single", pulses, 0);
        chk("flush_idle_ready", bus.fe_port_ready_o, 1);
        bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== ref_mem[k]) bad++;
        chk("flush_mem_image", bad, 0);
    endtask

    task automatic do_reset_mid();
        int n, bad;
        wait_rdy();
        bus.fe_address_i = 8'h44; bus.fe_read_write_select_i = 1'b0;
        bus.fe_address_valid_i = 1'b1; bus.fe_write_data_valid_i = 1'b0;
        @(posedge clk); #1;
        bus.fe_address_valid_i = 1'b0;
        n = 0;
        while (!(bus.be_address_valid_o && !bus.be_read_write_select_o) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        while (bus.be_address_valid_o && n < 200) begin @(posedge clk); #1; n++; end
        chk("reach_refill_wait", n < 200, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_flags", {bus.fe_read_data_valid_o, bus.fe_write_done_o, bus.fe_hit_o,
                          bus.be_address_valid_o, bus.be_write_data_valid_o,
                          bus.be_read_write_select_o, flush_done}, 0);
        chk("rst_rdata", bus.fe_read_data_o, 0);
        chk("rst_be_addr", bus.be_address_o, 0);
        chk("rst_be_wdata", bus.be_write_data_o, 0);
        chk("rst_ready", bus.fe_port_ready_o, 1);
        bad = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (!bus.fe_port_ready_o || bus.fe_read_data_valid_o || bus.be_address_valid_o) bad++;
        end
        chk("rst_late_ignored", bad, 0);
        for (int s = 0; s < 4; s++) begin rv[s] = 0; rdt[s] = 0; end
        for (int k = 0; k < 256; k++) ref_mem[k] = mem[k];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        bit rw, wf;
        logic [7:0] a;
        for (int k = 0; k < 256; k++) ref_mem[k] = 16'(k + 16'h100);
        for (int s = 0; s < 4; s++) begin rv[s] = 0; rt[s] = 0; rdt[s] = 0; end
        reset = 1'b1; flush = 1'b0;
        bus.fe_address_i = '0; bus.fe_address_valid_i = 1'b0; bus.fe_write_data_i = '0;
        bus.fe_write_data_valid_i = 1'b0; bus.fe_read_write_select_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("init_flags", {bus.fe_read_data_valid_o, bus.fe_write_done_o, bus.fe_hit_o,
                           bus.be_address_valid_o, bus.be_write_data_valid_o, flush_done}, 0);
        chk("init_ready", bus.fe_port_ready_o, 1);

        do_req(0, 8'h10, 16'h0, 0);
        do_req(0, 8'h11, 16'h0, 0);
        do_req(1, 8'h11, 16'hBEEF, 0);
        do_req(0, 8'h11, 16'h0, 0);
        do_req(0, 8'h30, 16'h0, 0);
        chk("evicted_word", mem[8'h11], 16'hBEEF);

        do_req(1, 8'h00, 16'h1234, 0);
        do_req(1, 8'h05, 16'h5678, 0);
        do_req(0, 8'h02, 16'h0, 0);
        do_flush(1, 0);
        do_req(0, 8'h00, 16'h0, 0);

        do_req(0, 8'h01, 16'h0, 1);
        do_flush(0, 1);

        do_req(0, 8'h21, 16'h0, 0);
        do_reset_mid();
        do_req(0, 8'h21, 16'h0, 0);

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                do_flush(bit'($urandom_range(0, 1)), 0);
            end else begin
                rw = bit'($urandom_range(0, 1));
                a  = 8'($urandom_range(0, 63));
                wf = ($urandom_range(0, 24) == 0);
                do_req(rw, a, 16'($urandom), wf);
                if (wf) do_flush(0, 1);
            end
        end
        do_flush(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/l1_cache_wb.md
Name: l1_cache_wb

Overview:
- Parametrised direct-mapped L1 cache: write-back, write-allocate, with multi-word blocks and real flush support.
- Sits between a requester (fe_* port) and a backing memory or next cache level (be_* port), in the cache_wrapper hierarchy.
- The be_* port uses the same word-level handshake as functional_memory.
- Adds per-line dirty bits, victim write-back, multi-word refill, a working flush sequence and flush completion signalling.

Parameters:
- DATA_WIDTH, 16, width of one word (frontend and backend).
- ADDRESS_WIDTH, 8, word-address width.
- NUM_SETS, 4, number of lines; power of two, at least 2.
- WORDS_PER_BLOCK, 2, words per line; power of two, at least 1.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- flush_i  in  1  flush request, single-cycle pulse or level.
- flush_done_o  out  1  one-cycle pulse when a flush completes.
- fe_address_i  in  ADDRESS_WIDTH  request word address.
- fe_address_valid_i  in  1  request valid.
- fe_write_data_i  in  DATA_WIDTH  write data.
- fe_write_data_valid_i  in  1  write data valid.
- fe_read_write_select_i  in  1  0 = read, 1 = write.
- fe_read_data_o  out  DATA_WIDTH  read data.
- fe_read_data_valid_o  out  1  read complete.
- fe_write_done_o  out  1  write complete.
- fe_port_ready_o  out  1  cache can accept a request.
- fe_hit_o  out  1  current/last request hit.
- be_read_data_i  in  DATA_WIDTH  backend read data.
- be_read_data_valid_i  in  1  backend read complete.
- be_write_done_i  in  1  backend write complete.
- be_port_ready_i  in  1  backend idle.
- be_address_o  out  ADDRESS_WIDTH  backend address.
- be_address_valid_o  out  1  backend request valid.
- be_write_data_o  out  DATA_WIDTH  backend write data.
- be_write_data_valid_o  out  1  backend write data valid.
- be_read_write_select_o  out  1  backend 0 = read, 1 = write.

Behaviour:
- Address split, LSB first:
  - OFF = log2(WORDS_PER_BLOCK) bits of word offset (zero bits when WORDS_PER_BLOCK = 1).
  - IDX = log2(NUM_SETS) bits of index.
  - Remaining bits are the tag.
- Reset (reset_i high at a rising edge):
  - All outputs go to 0 except fe_port_ready_o, which is 1 from the following cycle.
  - All valid and dirty bits clear; flush_pending clears; FSM goes to IDLE.
  - Any in-flight backend transaction is abandoned.
  - Late be_read_data_valid_i or be_write_done_i pulses received in IDLE are ignored.
- States:
  - IDLE, LOOKUP, RESPOND, EVICT_REQ, EVICT_WAIT, REFILL_REQ, REFILL_WAIT, FLUSH_SCAN, FLUSH_REQ, FLUSH_WAIT.
- fe_port_ready_o is 1 only when state is IDLE and flush_pending = 0.
- IDLE:
  - A request is accepted when fe_port_ready_o = 1, fe_address_valid_i = 1, and either the select is read, or it is write with fe_write_data_valid_i = 1.
  - On acceptance: latch address, data and select; clear fe_read_data_valid_o, fe_write_done_o and fe_hit_o; go to LOOKUP.
  - If flush_pending (or flush_i) is set and no request is accepted, go to FLUSH_SCAN.
- Flush latching:
  - flush_i is latched into flush_pending in any state except the FLUSH_* states.
  - A request and flush_i in the same IDLE cycle: the request is accepted, and the flush runs after the request completes.
- LOOKUP: fe_hit_o is registered as valid[idx] and (tag[idx] == tag).
  - Hit: go to RESPOND.
  - Miss with victim valid and dirty: go to EVICT_REQ with word counter w = 0.
  - Miss otherwise: go to REFILL_REQ with w = 0.
- RESPOND:
  - Read: fe_read_data_o = data[idx][off] and fe_read_data_valid_o = 1.
  - Write: data[idx][off] = write data, dirty[idx] = 1, fe_write_done_o = 1.
  - Then go to IDLE.
  - Hit latency: the response is visible 2 rising edges after the acceptance edge, and fe_port_ready_o is high in that same cycle.
  - fe_read_data_valid_o, fe_write_done_o and fe_read_data_o hold until the next acceptance.
- Backend word transaction (shared by EVICT, REFILL and FLUSH):
  - *_REQ drives be_address_o, be_read_write_select_o and be_write_data_o, and asserts be_address_valid_o (plus be_write_data_valid_o for writes).
  - Both valid signals hold until an edge where be_port_ready_i = 1, then drop; go to *_WAIT.
  - *_WAIT waits for be_write_done_i (write) or be_read_data_valid_i (read). A read stores be_read_data_i into data[idx][w].
  - w then increments. When w reaches WORDS_PER_BLOCK - 1 the phase ends; otherwise return to *_REQ.
- EVICT:
  - Writes word w of the victim to address {tag[idx], idx, w}.
  - At phase end: dirty[idx] = 0, go to REFILL_REQ with w = 0.
- REFILL:
  - Reads address {tag, idx, w}. The block is always fully fetched, including for write misses.
  - At phase end: valid[idx] = 1, tag[idx] = tag, dirty[idx] = 0, go to RESPOND.
  - A write miss then merges its word and sets dirty in RESPOND.
- FLUSH:
  - FLUSH_SCAN walks the set counter s from 0 to NUM_SETS - 1, one set per cycle.
  - Dirty and valid lines get a write-back of all words through FLUSH_REQ/FLUSH_WAIT.
  - Each line gets valid = 0 and dirty = 0.
  - After the last set: pulse flush_done_o for one cycle, clear flush_pending, go to IDLE.
  - A flush_i pulse during a flush is absorbed and does not trigger a second flush.
- Counters wrap naturally at their widths. No backend traffic occurs on hits, including write hits.

Test Plan (defaults: offset = bit0, idx = bits2:1, tag = bits7:3; backing memory preloaded with mem[a] = a + 0x100):
- Cold read 0x10 -> backend reads 0x10 then 0x11; fe_read_data_o = 0x0110, fe_hit_o = 0. Then read 0x11 -> 0x0111 at acceptance + 2 cycles, fe_hit_o = 1, zero be_address_valid_o pulses.
- Write 0x11 = 0xBEEF (hit) -> fe_write_done_o at +2 cycles, no backend write; read 0x11 -> 0xBEEF.
- Read 0x30 (same idx, tag 6) -> backend writes 0x10 = 0x0110 and 0x11 = 0xBEEF, then reads 0x30 and 0x31; returns 0x0130 with fe_hit_o = 0; memory now holds mem[0x11] = 0xBEEF.
- Dirty lines at idx 0 and 2 plus clean line at idx 1, then flush_i pulse -> exactly 4 backend writes; flush_done_o single pulse; fe_port_ready_o low throughout; next read of any prior address misses.
- flush_i in the same cycle as an accepted read hit -> read completes first (data valid), then the flush sequence runs, then flush_done_o.
- reset_i asserted during REFILL_WAIT -> outputs zero next cycle; a late be_read_data_valid_i is ignored; previously cached address misses after reset.
